// File: rtl/led_pkg.sv
// Shared types for the status-LED controller: the mode encoding and its reset value.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SLOW    = 2'd1,
        MODE_FAST    = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_t;

    localparam led_mode_t MODE_RESET = MODE_SLOW;

    // Press order OFF -> SLOW -> FAST -> BREATHE -> OFF.
    function automatic led_mode_t next_mode(input led_mode_t m);
        led_mode_t n;
        n = MODE_RESET;
        case (m)
            MODE_OFF:     n = MODE_SLOW;
            MODE_SLOW:    n = MODE_FAST;
            MODE_FAST:    n = MODE_BREATHE;
            MODE_BREATHE: n = MODE_OFF;
            default:      n = MODE_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_mode_sequencer_button_debounce.sv
// Button front end: 2-flop synchroniser, level debounce, and a one-cycle strobe on each accepted press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          b_meta_q;
    logic          b_s_q;
    logic          deb_lvl_q, deb_lvl_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic          press_pulse_q, press_pulse_d;

    // The counter is cleared on acceptance, so it can never run past DEB_LAST.
    always_comb begin
        deb_lvl_d     = deb_lvl_q;
        deb_cnt_d     = '0;
        press_pulse_d = 1'b0;
        if (b_s_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_lvl_d     = b_s_q;
                press_pulse_d = b_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_meta_q      <= 1'b0;
            b_s_q         <= 1'b0;
            deb_lvl_q     <= 1'b0;
            deb_cnt_q     <= '0;
            press_pulse_q <= 1'b0;
        end else begin
            b_meta_q      <= button;
            b_s_q         <= b_meta_q;
            deb_lvl_q     <= deb_lvl_d;
            deb_cnt_q     <= deb_cnt_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    assign press_pulse = press_pulse_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Status-LED controller: each debounced press steps the mode; the LED pattern is derived from one
// free-running counter that restarts at phase 0 whenever the mode changes.
//
//   state        | meaning
//   MODE_OFF     | LED held low
//   MODE_SLOW    | LED = cnt[SLOW_BIT] square wave (reset state)
//   MODE_FAST    | LED = cnt[FAST_BIT] square wave
//   MODE_BREATHE | LED = PWM with a triangle duty ramp
module led_mode_sequencer
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 27,
    parameter int SLOW_BIT        = 26,
    parameter int FAST_BIT        = 23,
    parameter int PWM_BITS        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    output logic       led,
    output logic [1:0] mode,
    output logic       press_pulse
);

    logic press;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .press_pulse(press)
    );

    led_mode_t            mode_q, mode_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 led_q, led_d;
    logic [PWM_BITS-1:0]  ramp;
    logic [PWM_BITS-1:0]  tri_val;
    logic                 breathe_led;

    always_comb begin
        mode_d = press ? next_mode(mode_q) : mode_q;
        cnt_d  = press ? '0 : cnt_q + CNT_W'(1);
    end

    // Upper counter bits give the duty; the MSB mirrors it so brightness rises then falls.
    always_comb begin
        ramp        = cnt_q[CNT_W-2 -: PWM_BITS];
        tri_val     = cnt_q[CNT_W-1] ? ~ramp : ramp;
        breathe_led = (cnt_q[PWM_BITS-1:0] < tri_val);
    end

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_OFF:     led_d = 1'b0;
            MODE_SLOW:    led_d = cnt_q[SLOW_BIT];
            MODE_FAST:    led_d = cnt_q[FAST_BIT];
            MODE_BREATHE: led_d = breathe_led;
            default:      led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_RESET;
            cnt_q  <= '0;
            led_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
        end
    end

    assign led         = led_q;
    assign mode        = mode_q;
    assign press_pulse = press;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: press scoreboard plus directed LED timing checks.
module tb_led_mode_sequencer;

    localparam int DC = 4;
    localparam int CW = 8;
    localparam int SB = 5;
    localparam int FB = 2;
    localparam int PB = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       button = 1'b0;
    logic       led;
    logic [1:0] mode;
    logic       press_pulse;

    led_mode_sequencer #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CW),
        .SLOW_BIT       (SB),
        .FAST_BIT       (FB),
        .PWM_BITS       (PB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .led        (led),
        .mode       (mode),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        int c;
        int m;
    } press_exp_t;

    press_exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the next queued press; the mode is checked one cycle later.
    bit mode_pend = 1'b0;
    int pend_mode = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mode_pend) begin
                check("mode_after_press", mode, pend_mode);
                mode_pend = 1'b0;
            end
            if (press_pulse === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_press", press_pulse, 0);
                end else begin
                    press_exp_t e;
                    e = exp_q.pop_front();
                    check("press_cycle", cyc, e.c);
                    pend_mode = e.m;
                    mode_pend = 1'b1;
                end
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic at_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Strobe expected DC+2 edges after the button rises (2 sync + DC debounce); mode/cnt update one edge later.
    task automatic press(input int hold, input int next_m, output int entry);
        press_exp_t e;
        button = 1'b1;
        e.c    = cyc + DC + 2;
        e.m    = next_m;
        exp_q.push_back(e);
        entry  = e.c + 1;
        wait_edges(hold);
        button = 1'b0;
    endtask

    function automatic logic exp_breathe(input int k);
        logic [7:0] c;
        logic [3:0] r;
        logic [3:0] t;
        c = k[7:0];
        r = c[6:3];
        t = c[7] ? ~r : r;
        return (c[3:0] < t);
    endfunction

    initial begin
        int r0, c0, e2, e3, e0, e1, ex;
        repeat (3) @(negedge clk);
        check("reset_mode", mode, 1);
        check("reset_led", led, 0);
        check("reset_press", press_pulse, 0);

        // SLOW after reset: cnt = k after edge r0+k, led lags by one edge.
        rst_n = 1'b1;
        r0    = cyc;
        at_cycle(r0 + 1);  check("slow_led_first", led, 0);
        at_cycle(r0 + 32); check("slow_led_c32", led, 0);
        at_cycle(r0 + 33); check("slow_led_c33", led, 1);
        at_cycle(r0 + 64); check("slow_led_c64", led, 1);
        at_cycle(r0 + 65); check("slow_led_c65", led, 0);
        check("slow_mode", mode, 1);

        // Short glitch must not count as a press.
        button = 1'b1;
        wait_edges(3);
        button = 1'b0;
        wait_edges(10);
        check("glitch_mode", mode, 1);

        // Long press into FAST, then check phase-0 restart and 8-cycle period.
        c0 = cyc;
        press(10, 2, e2);
        check("press_entry_calc", e2, c0 + 7);
        at_cycle(e2 + 1);  check("fast_led_e1", led, 0);
        at_cycle(e2 + 4);  check("fast_led_e4", led, 0);
        at_cycle(e2 + 5);  check("fast_led_e5", led, 1);
        at_cycle(e2 + 8);  check("fast_led_e8", led, 1);
        at_cycle(e2 + 9);  check("fast_led_e9", led, 0);
        at_cycle(e2 + 13); check("fast_led_e13", led, 1);
        wait_edges(12);

        // BREATHE over one full counter period.
        press(5, 3, e3);
        for (int k = 0; k < 256; k++) begin
            at_cycle(e3 + k + 1);
            check("breathe_led", led, exp_breathe(k));
        end
        wait_edges(4);

        // OFF holds the LED low.
        press(5, 0, e0);
        for (int i = 1; i <= 300; i++) begin
            at_cycle(e0 + i);
            check("off_led", led, 0);
        end

        press(5, 1, e1);
        wait_edges(12);
        check("wrap_to_slow", mode, 1);
        press(5, 2, ex);
        wait_edges(12);
        press(5, 3, ex);
        wait_edges(12);
        check("mode_breathe_again", mode, 3);
        check("pending_before_reset", exp_q.size(), 0);

        // Async reset mid-debounce, button kept high across reset.
        button = 1'b1;
        wait_edges(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_mode", mode, 1);
        check("async_rst_press", press_pulse, 0);
        wait_edges(2);
        rst_n = 1'b1;
        r0    = cyc;
        begin
            press_exp_t e;
            e.c = r0 + DC + 2;
            e.m = 2;
            exp_q.push_back(e);
        end
        wait_edges(12);
        button = 1'b0;
        wait_edges(12);
        check("post_reset_mode", mode, 2);
        check("pending_presses", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
